// File: rtl/iob_split_pipe_pkg.sv
// +----------------------------------------------------------------------------+
// | iob_split_pipe_pkg: defaults and helpers shared by split/merge bus blocks  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package iob_split_pipe_pkg;

  localparam int unsigned DEF_SEL_MSB  = 31;
  localparam int unsigned DEF_SEL_W    = 2;
  localparam logic [31:0] DEF_ERR_DATA = 32'hDEAD_BEEF;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/iob_split_tracker.sv
// +----------------------------------------------------------------------------+
// | iob_split_tracker: outstanding-request counter, target index, error slot  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module iob_split_tracker
  import iob_split_pipe_pkg::*;
#(
  parameter int MAX_OUT = 4,
  parameter int IDX_W   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] idx,
  input  logic             mapped,
  input  logic             acc,
  input  logic             cur_rvalid,
  output logic             can_issue,
  output logic [IDX_W-1:0] cur_idx,
  output logic             err,
  output logic             rsp,
  output logic             busy
);

  localparam int CNT_W = clog2(MAX_OUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] cur_idx_q, cur_idx_d;
  logic             err_q, err_d;

  // Responses from a slave other than the current target are ignored, and an
  // unmapped target never listens to slaves since its response is err_q.
  always_comb begin
    can_issue = (cnt_q == '0) | ((idx == cur_idx_q) & (cnt_q < CNT_W'(MAX_OUT)));
    rsp       = ((cnt_q != '0) & cur_rvalid) | err_q;
    cnt_d     = cnt_q + CNT_W'(acc) - CNT_W'(rsp);
    cur_idx_d = acc ? idx : cur_idx_q;
    err_d     = acc & ~mapped;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      cur_idx_q <= '0;
      err_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      cur_idx_q <= cur_idx_d;
      err_q     <= err_d;
    end
  end

  assign cur_idx = cur_idx_q;
  assign err     = err_q;
  assign busy    = (cnt_q != '0);

endmodule

`default_nettype wire

// File: rtl/iob_split_pipe.sv
// +----------------------------------------------------------------------------+
// | iob_split_pipe: one master to N_SLAVES slaves, pipelined, in-order resps  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module iob_split_pipe
  import iob_split_pipe_pkg::*;
#(
  parameter int              N_SLAVES = 4,
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter int              SEL_MSB  = DEF_SEL_MSB,
  parameter int              SEL_W    = DEF_SEL_W,
  parameter int              MAX_OUT  = 4,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(DEF_ERR_DATA)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       m_valid,
  input  logic [ADDR_W-1:0]          m_addr,
  input  logic [DATA_W-1:0]          m_wdata,
  input  logic [DATA_W/8-1:0]        m_wstrb,
  output logic                       m_ack,
  output logic                       m_rvalid,
  output logic [DATA_W-1:0]          m_rdata,
  output logic                       m_rerr,
  output logic [N_SLAVES-1:0]        s_valid,
  output logic [ADDR_W-1:0]          s_addr,
  output logic [DATA_W-1:0]          s_wdata,
  output logic [DATA_W/8-1:0]        s_wstrb,
  input  logic [N_SLAVES-1:0]        s_ack,
  input  logic [N_SLAVES-1:0]        s_rvalid,
  input  logic [N_SLAVES*DATA_W-1:0] s_rdata,
  output logic                       busy
);

  // One extra index bit so the unmapped target (index N_SLAVES) is distinct.
  localparam int IDX_W = SEL_W + 1;

  logic [SEL_W-1:0]  sel;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  cur_idx;
  logic              mapped;
  logic              can_issue;
  logic              req_ok;
  logic              sel_ack;
  logic              cur_rvalid;
  logic [DATA_W-1:0] cur_rdata;
  logic              err;
  logic              rsp;

  assign sel    = m_addr[SEL_MSB -: SEL_W];
  assign mapped = ({1'b0, sel} < IDX_W'(N_SLAVES));
  assign idx    = mapped ? {1'b0, sel} : IDX_W'(N_SLAVES);

  // rst gating keeps the handshake quiet while the tracker is held in reset.
  assign req_ok = m_valid & can_issue & ~rst;
  assign m_ack  = req_ok & (mapped ? sel_ack : 1'b1);

  for (genvar i = 0; i < N_SLAVES; i++) begin : g_slave_valid
    assign s_valid[i] = req_ok & mapped & (idx == IDX_W'(i));
  end

  always_comb begin
    sel_ack    = 1'b0;
    cur_rvalid = 1'b0;
    cur_rdata  = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (idx == IDX_W'(i)) sel_ack = s_ack[i];
      if (cur_idx == IDX_W'(i)) begin
        cur_rvalid = s_rvalid[i];
        cur_rdata  = s_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  iob_split_tracker #(
    .MAX_OUT (MAX_OUT),
    .IDX_W   (IDX_W)
  ) u_tracker (
    .clk        (clk),
    .rst        (rst),
    .idx        (idx),
    .mapped     (mapped),
    .acc        (m_ack),
    .cur_rvalid (cur_rvalid),
    .can_issue  (can_issue),
    .cur_idx    (cur_idx),
    .err        (err),
    .rsp        (rsp),
    .busy       (busy)
  );

  assign s_addr   = m_addr;
  assign s_wdata  = m_wdata;
  assign s_wstrb  = m_wstrb;
  assign m_rvalid = rsp;
  assign m_rdata  = err ? ERR_DATA : cur_rdata;
  assign m_rerr   = err;

endmodule

`default_nettype wire

// File: tb/tb_iob_split_pipe.sv
// +----------------------------------------------------------------------------+
// | tb_iob_split_pipe: directed vectors with scoreboarded responses           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_iob_split_pipe;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clk;
  logic rst;

  // Four-slave instance
  logic         m_valid;
  logic [31:0]  m_addr;
  logic [31:0]  m_wdata;
  logic [3:0]   m_wstrb;
  logic         m_ack;
  logic         m_rvalid;
  logic [31:0]  m_rdata;
  logic         m_rerr;
  logic [3:0]   s_valid;
  logic [31:0]  s_addr;
  logic [31:0]  s_wdata;
  logic [3:0]   s_wstrb;
  logic [3:0]   s_ack;
  logic [3:0]   s_rvalid;
  logic [127:0] s_rdata;
  logic         busy;

  // Three-slave instance, index 3 unmapped
  logic         u3_m_valid;
  logic [31:0]  u3_m_addr;
  logic [31:0]  u3_m_wdata;
  logic [3:0]   u3_m_wstrb;
  logic         u3_m_ack;
  logic         u3_m_rvalid;
  logic [31:0]  u3_m_rdata;
  logic         u3_m_rerr;
  logic [2:0]   u3_s_valid;
  logic [31:0]  u3_s_addr;
  logic [31:0]  u3_s_wdata;
  logic [3:0]   u3_s_wstrb;
  logic [2:0]   u3_s_ack;
  logic [2:0]   u3_s_rvalid;
  logic [95:0]  u3_s_rdata;
  logic         u3_busy;

  int   total;
  int   bad;
  exp_t q4[$];
  exp_t q3[$];

  iob_split_pipe #(.N_SLAVES(4)) dut (
    .clk(clk), .rst(rst),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_ack(m_ack), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rerr(m_rerr),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ack(s_ack), .s_rvalid(s_rvalid), .s_rdata(s_rdata), .busy(busy)
  );

  iob_split_pipe #(.N_SLAVES(3)) dut3 (
    .clk(clk), .rst(rst),
    .m_valid(u3_m_valid), .m_addr(u3_m_addr), .m_wdata(u3_m_wdata), .m_wstrb(u3_m_wstrb),
    .m_ack(u3_m_ack), .m_rvalid(u3_m_rvalid), .m_rdata(u3_m_rdata), .m_rerr(u3_m_rerr),
    .s_valid(u3_s_valid), .s_addr(u3_s_addr), .s_wdata(u3_s_wdata), .s_wstrb(u3_s_wstrb),
    .s_ack(u3_s_ack), .s_rvalid(u3_s_rvalid), .s_rdata(u3_s_rdata), .busy(u3_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int i, input logic [31:0] d);
    s_rdata[i*32 +: 32] = d;
  endtask

  // Response monitors: every m_rvalid must match the oldest expectation.
  always @(negedge clk) begin
    if (m_rvalid === 1'b1) begin
      total++;
      if (q4.size() == 0) begin
        bad++;
        $display("FAIL rsp4_unexpected: got data %h err %b want no response", m_rdata, m_rerr);
      end else begin
        exp_t e;
        e = q4.pop_front();
        if (m_rdata !== e.data || m_rerr !== e.err) begin
          bad++;
          $display("FAIL rsp4: got data %h err %b want data %h err %b", m_rdata, m_rerr, e.data, e.err);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (u3_m_rvalid === 1'b1) begin
      total++;
      if (q3.size() == 0) begin
        bad++;
        $display("FAIL rsp3_unexpected: got data %h err %b want no response", u3_m_rdata, u3_m_rerr);
      end else begin
        exp_t e;
        e = q3.pop_front();
        if (u3_m_rdata !== e.data || u3_m_rerr !== e.err) begin
          bad++;
          $display("FAIL rsp3: got data %h err %b want data %h err %b", u3_m_rdata, u3_m_rerr, e.data, e.err);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    m_valid = 1'b1; m_addr = 32'h8000_0000; m_wdata = 32'h0; m_wstrb = 4'h0;
    s_ack = 4'hF; s_rvalid = 4'h0; s_rdata = '0;
    u3_m_valid = 1'b0; u3_m_addr = 32'h0; u3_m_wdata = 32'h0; u3_m_wstrb = 4'h0;
    u3_s_ack = 3'b000; u3_s_rvalid = 3'b000; u3_s_rdata = '0;

    // Reset: outputs quiet even with a request pending
    smp();
    check("rst_ack", 32'(m_ack), 32'd0);
    check("rst_svalid", 32'(s_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rvalid", 32'(m_rvalid), 32'd0);
    check("rst_rerr", 32'(m_rerr), 32'd0);
    nxt();
    rst = 1'b0; m_valid = 1'b0; s_ack = 4'h0;

    // 1: single read to slave 2
    m_valid = 1'b1; m_addr = 32'h8000_0010; s_ack = 4'b0100;
    smp();
    check("t1_ack", 32'(m_ack), 32'd1);
    check("t1_svalid", 32'(s_valid), 32'b0100);
    q4.push_back('{data: 32'h0000_1234, err: 1'b0});
    nxt();
    m_valid = 1'b0; s_ack = 4'h0; s_rvalid = 4'b0100; set_rd(2, 32'h0000_1234);
    smp();
    check("t1_rvalid", 32'(m_rvalid), 32'd1);
    nxt();
    s_rvalid = 4'h0;
    smp();
    check("t1_idle", 32'(busy), 32'd0);
    nxt();

    // 2: fill four outstanding to slave 1, fifth waits past the first response
    m_valid = 1'b1; m_addr = 32'h4000_0000; s_ack = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      smp();
      check("t2_ack", 32'(m_ack), 32'd1);
      q4.push_back('{data: 32'hA0 + 32'(k), err: 1'b0});
      nxt();
    end
    smp();
    check("t2_full_ack", 32'(m_ack), 32'd0);
    check("t2_full_svalid", 32'(s_valid), 32'd0);
    nxt();
    s_rvalid = 4'b0010; set_rd(1, 32'hA0);
    smp();
    check("t2_nobypass", 32'(m_ack), 32'd0);
    nxt();
    s_rvalid = 4'h0;
    smp();
    check("t2_fifth_ack", 32'(m_ack), 32'd1);
    q4.push_back('{data: 32'hA4, err: 1'b0});
    nxt();
    m_valid = 1'b0; s_ack = 4'h0;
    for (int k = 1; k <= 4; k++) begin
      s_rvalid = 4'b0010; set_rd(1, 32'hA0 + 32'(k));
      smp();
      nxt();
    end
    s_rvalid = 4'h0;
    smp();
    check("t2_drained", 32'(busy), 32'd0);
    nxt();

    // 3: request to slave 3 stalls behind outstanding slave 0
    m_valid = 1'b1; m_addr = 32'h0000_0000; s_ack = 4'b1001;
    smp();
    check("t3_ack0", 32'(m_ack), 32'd1);
    q4.push_back('{data: 32'h0000_5000, err: 1'b0});
    nxt();
    m_addr = 32'hC000_0000;
    for (int k = 0; k < 2; k++) begin
      smp();
      check("t3_stall_ack", 32'(m_ack), 32'd0);
      check("t3_stall_svalid", 32'(s_valid), 32'd0);
      nxt();
    end
    s_rvalid = 4'b0001; set_rd(0, 32'h0000_5000);
    smp();
    check("t3_rsp_ack", 32'(m_ack), 32'd0);
    nxt();
    s_rvalid = 4'h0;
    smp();
    check("t3_svalid3", 32'(s_valid), 32'b1000);
    check("t3_ack3", 32'(m_ack), 32'd1);
    q4.push_back('{data: 32'h0000_3333, err: 1'b0});
    nxt();
    m_valid = 1'b0; s_ack = 4'h0; s_rvalid = 4'b1000; set_rd(3, 32'h0000_3333);
    smp();
    nxt();
    s_rvalid = 4'h0;
    smp();
    check("t3_idle", 32'(busy), 32'd0);
    nxt();

    // 4: unmapped writes on the three-slave instance, back to back
    u3_m_valid = 1'b1; u3_m_addr = 32'hC000_0004; u3_m_wstrb = 4'hF; u3_m_wdata = 32'h1111_2222;
    for (int k = 0; k < 2; k++) begin
      smp();
      check("t4_ack", 32'(u3_m_ack), 32'd1);
      check("t4_svalid", 32'(u3_s_valid), 32'd0);
      q3.push_back('{data: 32'hDEAD_BEEF, err: 1'b1});
      nxt();
    end
    u3_m_valid = 1'b0; u3_m_wstrb = 4'h0;
    smp();
    check("t4_rvalid2", 32'(u3_m_rvalid), 32'd1);
    nxt();
    smp();
    check("t4_idle", 32'(u3_busy), 32'd0);
    nxt();

    // 5: stray response from slave 2 while slave 1 is outstanding
    m_valid = 1'b1; m_addr = 32'h4000_0000; s_ack = 4'b0010;
    smp();
    check("t5_ack", 32'(m_ack), 32'd1);
    q4.push_back('{data: 32'h0000_7777, err: 1'b0});
    nxt();
    m_valid = 1'b0; s_ack = 4'h0; s_rvalid = 4'b0100; set_rd(2, 32'hBAD0_0002);
    smp();
    check("t5_stray_rvalid", 32'(m_rvalid), 32'd0);
    check("t5_stray_busy", 32'(busy), 32'd1);
    nxt();
    s_rvalid = 4'b0010; set_rd(1, 32'h0000_7777);
    smp();
    nxt();
    s_rvalid = 4'h0;
    smp();
    check("t5_idle", 32'(busy), 32'd0);
    nxt();

    // 6: reset drops three outstanding requests; the late response is ignored
    m_valid = 1'b1; m_addr = 32'h8000_0000; s_ack = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      smp();
      check("t6_ack", 32'(m_ack), 32'd1);
      nxt();
    end
    rst = 1'b1;
    smp();
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_ack", 32'(m_ack), 32'd0);
    check("t6_rst_svalid", 32'(s_valid), 32'd0);
    nxt();
    rst = 1'b0; m_valid = 1'b0; s_ack = 4'h0; s_rvalid = 4'b0100; set_rd(2, 32'hBAD0_0006);
    smp();
    check("t6_late_rvalid", 32'(m_rvalid), 32'd0);
    check("t6_late_busy", 32'(busy), 32'd0);
    nxt();
    s_rvalid = 4'h0;
    smp();
    check("q4_empty", 32'(q4.size()), 32'd0);
    check("q3_empty", 32'(q3.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
